conv_mac_seq: RTL and testbench

Operand sequencer and result requantizer that drives an external fixed-point MAC slice. It accepts a stream of (sample, weight) pairs and issues one MAC enable per pair. It chains the MAC's registered sum back into its accumulate input over a window of `klen_i` terms. It then converts the 2N-bit Q(2Q) sum back to an N-bit QQ result with round-half-up and saturation. The block sits between the convolution line-buffer/weight-ROM front end and the output writer. All arithmetic is unsigned, matching the MAC's unsigned multiplier.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/fxp_requant.sv | 30 +++
 rtl/conv_mac_seq.sv | 134 +++++++++++++
 tb/tb_conv_mac_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared state type and fixed-point constants for the conv MAC sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_CAP = 2'd1,
    ST_OUT = 2'd2
  } conv_state_t;

  localparam int unsigned N_DEF     = 32'd16;
  localparam int unsigned Q_DEF     = 32'd12;
  localparam int unsigned K_MAX_DEF = 32'd64;

  // Offset that turns a truncating right shift by q into round-half-up.
  function automatic logic [63:0] rnd_half(input int unsigned q);
    return 64'd1 << (q - 32'd1);
  endfunction

  localparam logic [63:0] RND_HALF = rnd_half(Q_DEF);

endpackage

// File: rtl/fxp_requant.sv
// Combinational Q(2Q) -> QQ requantizer: round-half-up, shift by Q, saturate to N bits.
module fxp_requant
  import conv_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned Q = Q_DEF
) (
  input  logic [2*N-1:0] sum_i,
  output logic [N-1:0]   data_o,
  output logic           sat_o
);

  localparam logic [2*N:0] RND = (2*N+1)'(rnd_half(Q));

  logic [2*N:0] rounded;
  logic [2*N:0] shifted;

  // The extra MSB keeps the rounding carry from wrapping a near-full sum to zero.
  always_comb begin
    rounded = {1'b0, sum_i} + RND;
    shifted = rounded >> Q;
    sat_o   = |shifted[2*N:N];
    if (sat_o) begin
      data_o = {N{1'b1}};
    end else begin
      data_o = shifted[N-1:0];
    end
  end

endmodule

// File: rtl/conv_mac_seq.sv
// Operand sequencer and requantizer for an external unsigned fixed-point MAC slice.
// Optional build macro CONV_MAC_BIAS_EN adds bias_i << Q as the first term of each window.
module conv_mac_seq
  import conv_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned Q     = Q_DEF,
  parameter int unsigned K_MAX = K_MAX_DEF
) (
  input  logic                       clk,
  input  logic                       sclr,
  input  logic [$clog2(K_MAX+1)-1:0] klen_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [N-1:0]               in_a_i,
  input  logic [N-1:0]               in_b_i,
`ifdef CONV_MAC_BIAS_EN
  input  logic [N-1:0]               bias_i,
`endif
  output logic [N-1:0]               mac_a_o,
  output logic [N-1:0]               mac_b_o,
  output logic [2*N-1:0]             mac_c_o,
  output logic                       mac_ce_o,
  input  logic [2*N-1:0]             mac_r_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [N-1:0]               out_data_o,
  output logic                       out_sat_o
);

  localparam int unsigned   KW     = $clog2(K_MAX + 1);
  localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
  localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};

  conv_state_t   state_q;
  logic [KW-1:0] cnt_q;
  logic [KW-1:0] klen_q;
  logic          out_valid_q;
  logic          out_sat_q;
  logic [N-1:0]  out_data_q;

  logic [KW-1:0]  klen_sel;
  logic [KW-1:0]  klen_eff;
  logic           accept;
  logic           last_term;
  logic [2*N-1:0] init_term;
  logic [N-1:0]   rq_data;
  logic           rq_sat;

`ifdef CONV_MAC_BIAS_EN
  assign init_term = {{N{1'b0}}, bias_i} << Q;
`else
  assign init_term = {(2*N){1'b0}};
`endif

  fxp_requant #(.N(N), .Q(Q)) u_requant (
    .sum_i  (mac_r_i),
    .data_o (rq_data),
    .sat_o  (rq_sat)
  );

  // Handshake, MAC operand muxing and end-of-window detection; klen_i is only
  // sampled on the first term so mid-window changes have no effect.
  always_comb begin
    in_ready_o = (state_q == ST_ACC) && !sclr;
    accept     = in_valid_i && in_ready_o;
    mac_ce_o   = accept;
    mac_a_o    = in_a_i;
    mac_b_o    = in_b_i;
    if (cnt_q == K_ZERO) begin
      klen_sel = klen_i;
      mac_c_o  = init_term;
    end else begin
      klen_sel = klen_q;
      mac_c_o  = mac_r_i;
    end
    if (klen_sel == K_ZERO) begin
      klen_eff = K_ONE;
    end else begin
      klen_eff = klen_sel;
    end
    last_term = (cnt_q == (klen_eff - K_ONE));
  end

  // Window FSM with registered result and valid.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state_q     <= ST_ACC;
      cnt_q       <= K_ZERO;
      klen_q      <= K_ONE;
      out_valid_q <= 1'b0;
      out_data_q  <= {N{1'b0}};
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            if (cnt_q == K_ZERO) begin
              klen_q <= klen_eff;
            end
            if (last_term) begin
              cnt_q   <= K_ZERO;
              state_q <= ST_CAP;
            end else begin
              cnt_q <= cnt_q + K_ONE;
            end
          end
        end
        ST_CAP: begin
          out_data_q  <= rq_data;
          out_sat_q   <= rq_sat;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACC;
          end
        end
        default: begin
          cnt_q       <= K_ZERO;
          out_valid_q <= 1'b0;
          state_q     <= ST_ACC;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed self-checking bench for conv_mac_seq wired to a behavioural MAC slice.
module tb_conv_mac_seq;

  localparam int N     = 16;
  localparam int Q     = 12;
  localparam int K_MAX = 64;
  localparam int KW    = $clog2(K_MAX + 1);

  logic            clk = 1'b0;
  logic            sclr;
  logic [KW-1:0]   klen = 7'd1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N-1:0]    in_a = 16'h0000;
  logic [N-1:0]    in_b = 16'h0000;
`ifdef CONV_MAC_BIAS_EN
  logic [N-1:0]    bias = 16'h0000;
`endif
  logic [N-1:0]    mac_a;
  logic [N-1:0]    mac_b;
  logic [2*N-1:0]  mac_c;
  logic            mac_ce;
  logic [2*N-1:0]  mac_r;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N-1:0]    out_data;
  logic            out_sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_mac_seq #(.N(N), .Q(Q), .K_MAX(K_MAX)) dut (
    .clk         (clk),
    .sclr        (sclr),
    .klen_i      (klen),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
`ifdef CONV_MAC_BIAS_EN
    .bias_i      (bias),
`endif
    .mac_a_o     (mac_a),
    .mac_b_o     (mac_b),
    .mac_c_o     (mac_c),
    .mac_ce_o    (mac_ce),
    .mac_r_i     (mac_r),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_sat_o   (out_sat)
  );

  // MAC slice: registered r = c + a*b on ce, cleared by the shared reset.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) mac_r <= 32'h0000_0000;
    else if (mac_ce) mac_r <= mac_c + ({16'h0000, mac_a} * {16'h0000, mac_b});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    #1;
  endtask

  // Called while the last pair is presented; returns valid in CAP, then valid/data/sat in OUT.
  task automatic capture(output logic v_cap, output logic v_out, output logic [N-1:0] d, output logic s);
    step();
    in_valid = 1'b0;
    v_cap = out_valid;
    step();
    v_out = out_valid;
    d     = out_data;
    s     = out_sat;
  endtask

  task automatic test_reset();
    sclr = 1'b1; in_valid = 1'b1; in_a = 16'h1000; in_b = 16'h1000;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (mac_ce !== 1'b0) begin failures++; $display("FAIL rst_mac_ce: got %b want 0", mac_ce); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL rst_out_sat: got %b want 0", out_sat); end
    in_valid = 1'b0; sclr = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    logic vc, vo, s; logic [N-1:0] d;
    klen = 7'd1;
    drive(1'b1, 16'h1000, 16'h2000);
    checks++; if (mac_ce !== 1'b1) begin failures++; $display("FAIL single_ce: got %b want 1", mac_ce); end
    checks++; if (mac_a !== 16'h1000 || mac_b !== 16'h2000) begin failures++; $display("FAIL single_ab: got %h/%h want 1000/2000", mac_a, mac_b); end
    checks++; if (mac_c !== 32'h0) begin failures++; $display("FAIL single_c: got %h want 00000000", mac_c); end
    capture(vc, vo, d, s);
    checks++; if (vc !== 1'b0) begin failures++; $display("FAIL single_valid_cap: got %b want 0", vc); end
    checks++; if (vo !== 1'b1) begin failures++; $display("FAIL single_valid_out: got %b want 1", vo); end
    checks++; if (d !== 16'h2000 || s !== 1'b0) begin failures++; $display("FAIL single_data: got %h sat %b want 2000 sat 0", d, s); end
    step();
  endtask

  task automatic test_multi();
    logic vc, vo, s; logic [N-1:0] d;
    klen = 7'd3;
    drive(1'b1, 16'h1000, 16'h1000);
    checks++; if (in_ready !== 1'b1 || mac_c !== 32'h0) begin failures++; $display("FAIL multi_t0: ready %b c %h want 1 00000000", in_ready, mac_c); end
    step(); klen = 7'd1; #1;
    checks++; if (in_ready !== 1'b1 || mac_c !== 32'h0100_0000) begin failures++; $display("FAIL multi_t1: ready %b c %h want 1 01000000", in_ready, mac_c); end
    step();
    checks++; if (in_ready !== 1'b1 || mac_c !== 32'h0200_0000) begin failures++; $display("FAIL multi_t2: ready %b c %h want 1 02000000", in_ready, mac_c); end
    capture(vc, vo, d, s);
    checks++; if (vo !== 1'b1 || d !== 16'h3000 || s !== 1'b0) begin failures++; $display("FAIL multi_result: valid %b data %h sat %b want 1 3000 0", vo, d, s); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL multi_ready_out: got %b want 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL multi_next_window: got %b want 1", in_ready); end
  endtask

  task automatic test_rounding();
    logic vc, vo, s; logic [N-1:0] d;
    klen = 7'd0;
    drive(1'b1, 16'h0001, 16'h0800);
    capture(vc, vo, d, s);
    checks++; if (vo !== 1'b1 || d !== 16'h0001 || s !== 1'b0) begin failures++; $display("FAIL round_up_klen0: valid %b data %h sat %b want 1 0001 0", vo, d, s); end
    step();
    klen = 7'd1;
    drive(1'b1, 16'h0001, 16'h07FF);
    capture(vc, vo, d, s);
    checks++; if (vo !== 1'b1 || d !== 16'h0000 || s !== 1'b0) begin failures++; $display("FAIL round_down: valid %b data %h sat %b want 1 0000 0", vo, d, s); end
    step();
  endtask

  task automatic test_saturation();
    logic vc, vo, s; logic [N-1:0] d;
    klen = 7'd1;
    drive(1'b1, 16'hFFFF, 16'hFFFF);
    capture(vc, vo, d, s);
    checks++; if (vo !== 1'b1 || d !== 16'hFFFF || s !== 1'b1) begin failures++; $display("FAIL saturate: valid %b data %h sat %b want 1 ffff 1", vo, d, s); end
    step();
  endtask

  task automatic test_gap();
    logic vc, vo, s; logic [N-1:0] d;
    klen = 7'd2;
    drive(1'b1, 16'h1000, 16'h1000);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    checks++; if (in_ready !== 1'b1 || mac_ce !== 1'b0) begin failures++; $display("FAIL gap_pause: ready %b ce %b want 1 0", in_ready, mac_ce); end
    step();
    drive(1'b1, 16'h1000, 16'h1000);
    checks++; if (mac_c !== 32'h0100_0000) begin failures++; $display("FAIL gap_chain: c %h want 01000000", mac_c); end
    capture(vc, vo, d, s);
    checks++; if (vo !== 1'b1 || d !== 16'h2000) begin failures++; $display("FAIL gap_result: valid %b data %h want 1 2000", vo, d); end
    step();
  endtask

  task automatic test_backpressure();
    logic vc, vo, s; logic [N-1:0] d;
    klen = 7'd1; out_ready = 1'b0;
    drive(1'b1, 16'h1000, 16'h1000);
    capture(vc, vo, d, s);
    checks++; if (vo !== 1'b1 || d !== 16'h1000) begin failures++; $display("FAIL bp_result: valid %b data %h want 1 1000", vo, d); end
    drive(1'b1, 16'h2000, 16'h1000);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h1000) begin failures++; $display("FAIL bp_hold_%0d: valid %b data %h want 1 1000", i, out_valid, out_data); end
      checks++; if (in_ready !== 1'b0 || mac_ce !== 1'b0) begin failures++; $display("FAIL bp_stall_%0d: ready %b ce %b want 0 0", i, in_ready, mac_ce); end
      step();
    end
    out_ready = 1'b1; #1;
    step();
    checks++; if (in_ready !== 1'b1 || mac_ce !== 1'b1) begin failures++; $display("FAIL bp_resume: ready %b ce %b want 1 1", in_ready, mac_ce); end
    capture(vc, vo, d, s);
    checks++; if (vo !== 1'b1 || d !== 16'h2000) begin failures++; $display("FAIL bp_next: valid %b data %h want 1 2000", vo, d); end
    step();
  endtask

  task automatic test_reset_mid_window();
    logic vc, vo, s; logic [N-1:0] d;
    logic [N-1:0] exp_d; logic [2*N-1:0] exp_c;
    klen = 7'd4;
    drive(1'b1, 16'h1000, 16'h1000);
    step(); step();
    sclr = 1'b1; #1;
    checks++; if (in_ready !== 1'b0 || mac_ce !== 1'b0) begin failures++; $display("FAIL mid_rst_gate: ready %b ce %b want 0 0", in_ready, mac_ce); end
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0) begin failures++; $display("FAIL mid_rst_out: valid %b data %h sat %b want 0 0000 0", out_valid, out_data, out_sat); end
    step();
`ifdef CONV_MAC_BIAS_EN
    bias = 16'h1000; exp_d = 16'h2000; exp_c = 32'h0100_0000;
`else
    exp_d = 16'h1000; exp_c = 32'h0000_0000;
`endif
    klen = 7'd1; sclr = 1'b0;
    drive(1'b1, 16'h1000, 16'h1000);
    checks++; if (in_ready !== 1'b1 || mac_c !== exp_c) begin failures++; $display("FAIL mid_rst_init: ready %b c %h want 1 %h", in_ready, mac_c, exp_c); end
    capture(vc, vo, d, s);
    checks++; if (vo !== 1'b1 || d !== exp_d || s !== 1'b0) begin failures++; $display("FAIL mid_rst_result: valid %b data %h sat %b want 1 %h 0", vo, d, s, exp_d); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_rounding();
    test_saturation();
    test_gap();
    test_backpressure();
    test_reset_mid_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
